// File: rtl/vga_timing_pipelined.sv
// VGA timing generator with pixel-clock-enable divider, selectable sync
// polarity, line/frame strobes and a sync/blank delay line that keeps the
// syncs aligned with colour arriving from a multi-cycle pixel source.
//
// Qualifier semantics: pixel_tick is a one-clk enable. Every counter,
// pipeline stage and output register advances only on a clock where it is
// high. Between ticks everything holds except the tick and the two strobes.
module vga_timing_pipelined #(
  parameter int   clk_mhz        = 25,
  parameter int   pixel_mhz      = 25,
  parameter int   h_active       = 640,
  parameter int   h_front        = 16,
  parameter int   h_sync         = 96,
  parameter int   h_back         = 48,
  parameter int   v_active       = 480,
  parameter int   v_front        = 10,
  parameter int   v_sync         = 2,
  parameter int   v_back         = 33,
  parameter logic h_sync_pol     = 1'b0,
  parameter logic v_sync_pol     = 1'b0,
  parameter int   colour_latency = 0,
  parameter int   w_x            = $clog2(h_active + h_front + h_sync + h_back),
  parameter int   w_y            = $clog2(v_active + v_front + v_sync + v_back),
  parameter int   w_red          = 2,
  parameter int   w_green        = 2,
  parameter int   w_blue         = 2
) (
  input  logic               clk,
  input  logic               rst,
  output logic               pixel_tick,
  output logic [w_x-1:0]     x,
  output logic [w_y-1:0]     y,
  output logic               display_on,
  output logic               line_start,
  output logic               frame_start,
  input  logic [w_red-1:0]   red_in,
  input  logic [w_green-1:0] green_in,
  input  logic [w_blue-1:0]  blue_in,
  output logic               vga_hsync,
  output logic               vga_vsync,
  output logic [w_red-1:0]   vga_red,
  output logic [w_green-1:0] vga_green,
  output logic [w_blue-1:0]  vga_blue
);

  localparam int div     = clk_mhz / pixel_mhz;
  localparam int h_total = h_active + h_front + h_sync + h_back;
  localparam int v_total = v_active + v_front + v_sync + v_back;
  localparam int w_div   = (div > 1) ? $clog2(div) : 1;

  // Sync windows as half-open intervals [start, end) in counter units.
  localparam int hs_start = h_active + h_front;
  localparam int hs_end   = h_active + h_front + h_sync;
  localparam int vs_start = v_active + v_front;
  localparam int vs_end   = v_active + v_front + v_sync;

  localparam logic [w_div-1:0] div_last = w_div'(div - 1);
  localparam logic [w_x-1:0]   x_last   = w_x'(h_total - 1);
  localparam logic [w_y-1:0]   y_last   = w_y'(v_total - 1);

  // Elaboration-time parameter sanity.
  if ((pixel_mhz < 1) || (div < 1) || (div * pixel_mhz != clk_mhz)) begin : g_bad_div
    $error("vga_timing_pipelined: clk_mhz must be an integer multiple of pixel_mhz");
  end
  if ((colour_latency < 0) || (colour_latency > 4)) begin : g_bad_latency
    $error("vga_timing_pipelined: colour_latency must be in 0..4");
  end

  logic [w_div-1:0] div_cnt;
  logic             hs_raw;
  logic             vs_raw;
  logic             de_d;
  logic             hs_d;
  logic             vs_d;

  // Clock-enable divider: counts 0..div-1 and wraps.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt <= '0;
    end else if (div_cnt == div_last) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + w_div'(1);
    end
  end

  // Tick is masked by reset so nothing advances on the reset cycle itself.
  always_comb begin
    pixel_tick  = !rst && (div_cnt == div_last);
    display_on  = (32'(x) < h_active) && (32'(y) < v_active);
    line_start  = pixel_tick && (x == '0);
    frame_start = pixel_tick && (x == '0) && (y == '0);
    hs_raw      = (32'(x) >= hs_start) && (32'(x) < hs_end);
    vs_raw      = (32'(y) >= vs_start) && (32'(y) < vs_end);
  end

  // Raster counters: x wraps at end of line, y steps on that wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      x <= '0;
      y <= '0;
    end else if (pixel_tick) begin
      if (x == x_last) begin
        x <= '0;
        if (y == y_last) begin
          y <= '0;
        end else begin
          y <= y + w_y'(1);
        end
      end else begin
        x <= x + w_x'(1);
      end
    end
  end

  // Delay line matching the colour source latency; true means active sync.
  if (colour_latency == 0) begin : g_no_pipe
    assign de_d = display_on;
    assign hs_d = hs_raw;
    assign vs_d = vs_raw;
  end else begin : g_pipe
    logic [colour_latency-1:0] de_sr;
    logic [colour_latency-1:0] hs_sr;
    logic [colour_latency-1:0] vs_sr;

    // Shift one stage per pixel; reset leaves blanked, inactive contents.
    always_ff @(posedge clk) begin
      if (rst) begin
        de_sr <= '0;
        hs_sr <= '0;
        vs_sr <= '0;
      end else if (pixel_tick) begin
        de_sr[0] <= display_on;
        hs_sr[0] <= hs_raw;
        vs_sr[0] <= vs_raw;
        for (int i = 1; i < colour_latency; i++) begin
          de_sr[i] <= de_sr[i-1];
          hs_sr[i] <= hs_sr[i-1];
          vs_sr[i] <= vs_sr[i-1];
        end
      end
    end

    assign de_d = de_sr[colour_latency-1];
    assign hs_d = hs_sr[colour_latency-1];
    assign vs_d = vs_sr[colour_latency-1];
  end

  // Output registers: syncs at their configured polarity, colour blanked
  // outside the active area so undriven inputs never reach the pins.
  always_ff @(posedge clk) begin
    if (rst) begin
      vga_hsync <= ~h_sync_pol;
      vga_vsync <= ~v_sync_pol;
      vga_red   <= '0;
      vga_green <= '0;
      vga_blue  <= '0;
    end else if (pixel_tick) begin
      vga_hsync <= ~(hs_d ^ h_sync_pol);
      vga_vsync <= ~(vs_d ^ v_sync_pol);
      vga_red   <= de_d ? red_in   : '0;
      vga_green <= de_d ? green_in : '0;
      vga_blue  <= de_d ? blue_in  : '0;
    end
  end

endmodule

// File: doc/vga_timing_pipelined.md
Name: vga_timing_pipelined

Overview:
Parametrised VGA timing generator and output stage. It replaces the fixed 640x480 timing core plus the separate sync and colour output registers in the project/lab_top layer. It adds configurable timing, a pixel-clock-enable divider, selectable sync polarity, frame/line start strobes, and a configurable colour-pipeline latency, so syncs stay aligned with registered colour from a multi-cycle pixel source.

Parameters:
clk_mhz, 25, system clock frequency; must be an integer multiple of pixel_mhz (elaboration $error otherwise)
pixel_mhz, 25, pixel rate; div = clk_mhz / pixel_mhz
h_active, 640, visible pixels per line
h_front, 16, horizontal front porch (pixels)
h_sync, 96, horizontal sync width (pixels)
h_back, 48, horizontal back porch; h_total = sum of the four = 800
v_active, 480, visible lines
v_front, 10, vertical front porch (lines)
v_sync, 2, vertical sync width (lines)
v_back, 33, vertical back porch; v_total = 525
h_sync_pol, 0, active level of vga_hsync
v_sync_pol, 0, active level of vga_vsync
colour_latency, 0, pixel ticks from x/y presentation to valid colour input; range 0..4, $error outside
w_x, $clog2(h_total), x width
w_y, $clog2(v_total), y width
w_red / w_green / w_blue, 2 / 2 / 2, colour widths

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
pixel_tick  out  1  one-clk pulse per pixel; all counters and output registers advance only on it
x  out  w_x  current horizontal counter, 0..h_total-1
y  out  w_y  current vertical counter, 0..v_total-1
display_on  out  1  x < h_active && y < v_active
line_start  out  1  pixel_tick && x == 0
frame_start  out  1  pixel_tick && x == 0 && y == 0
red_in / green_in / blue_in  in  w_red / w_green / w_blue  pixel colour for the coordinate presented colour_latency ticks earlier
vga_hsync  out  1  registered horizontal sync
vga_vsync  out  1  registered vertical sync
vga_red / vga_green / vga_blue  out  w_*  registered colour, zero when blanked

Behaviour:
- Reset values: div_cnt = 0, x = 0, y = 0, pixel_tick = 0, all colour outputs = 0, vga_hsync = !h_sync_pol, vga_vsync = !v_sync_pol. All delay-pipeline stages load display_on = 0 and sync = inactive.
- Divider: div_cnt counts 0..div-1 and wraps. pixel_tick = !rst && (div_cnt == div-1).
  - div = 1: pixel_tick is high on every cycle after reset release.
  - div = 2: first tick on the 2nd cycle after release.
- Counters advance on pixel_tick only:
  - x wraps h_total-1 -> 0; on that wrap y increments.
  - y wraps v_total-1 -> 0 on the same tick that x wraps.
  - No other wrap points. Counters never leave their range.
- Raw timing for the current (x, y):
  - hs_raw active when h_active+h_front <= x < h_active+h_front+h_sync.
  - vs_raw active when v_active+v_front <= y < v_active+v_front+v_sync.
- Alignment pipeline:
  - hs_raw, vs_raw and display_on pass through a shift register of depth colour_latency that advances on pixel_tick only.
  - With colour_latency = 0 there is no shift register; the outputs use the current values directly.
  - Let de_d, hs_d, vs_d be the pipeline outputs.
- Output registers, updated on pixel_tick only:
  - vga_hsync <= hs_d XNOR h_sync_pol, i.e. the active level when hs_d is true.
  - vga_vsync <= vs_d XNOR v_sync_pol.
  - vga_red/green/blue <= de_d ? *_in : 0.
- Latency: coordinate presented at tick n appears on the VGA pins after tick n+colour_latency (colour_latency+1 ticks, incl. output reg). Syncs share exactly that delay.
- Between ticks, all outputs except pixel_tick, line_start and frame_start hold their values.
- Reset mid-frame: everything returns to reset values immediately. The first tick after release is x = 0, y = 0 with frame_start = 1. Stale pipeline contents are never driven, because reset clears them.
- Colour inputs are ignored while de_d = 0, including X or undriven values.

Test Plan:
- Defaults, constant colour in = 3/3/3:
  - frame_start on the 1st cycle after reset release, then every 420000 cycles.
  - line_start every 800 cycles.
- Defaults, hsync check: vga_hsync low for exactly 96 consecutive ticks, first low after the tick with x = 656. vga_vsync low for exactly 2 lines, starting on the line after y = 489.
- Blanking check: vga_red = 3 for exactly 640 ticks per active line and 0 at all other times; 0 on lines 480..524.
- clk_mhz = 50, pixel_mhz = 25:
  - pixel_tick alternates 0/1, first high on the 2nd cycle after release.
  - All outputs hold between ticks.
  - Line = 1600 cycles.
- colour_latency = 2, red_in = x[1:0] delayed 2 ticks by the bench: vga_red equals x[1:0] of the displayed pixel. The first active pixel of each line shows 0 and is aligned with hsync: its offset from the hsync falling edge is the same as with colour_latency = 0.
- h_sync_pol = 1, v_sync_pol = 1: syncs idle low after reset, high during sync windows. Assert rst mid-line at x = 300, y = 100 and release: outputs return to reset values, and the next tick gives frame_start = 1 with x = 0, y = 0.
